// File: rtl/pearl_pkg.sv
// Shared front-end constants for the pearl core.
package pearl_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned FETCH_WIDTH = 32;               // bits per fetched instruction word
   localparam int unsigned FETCH_BYTES = FETCH_WIDTH / 8;  // fetch PC stride

   // Width of a counter that must hold every value 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO for fetched {instruction, pc} entries; clear wins over push/pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   // Next-state for storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PW'(1);
         end
         if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Data storage needs no reset; entries are only read while counted as valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-limited fetch requests, in-order responses into a queue,
// flush/redirect that discards responses still in flight.
module if_prefetch
   import pearl_pkg::FETCH_BYTES;
   import pearl_pkg::cnt_width;
#(
   parameter int unsigned     XLEN      = pearl_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int unsigned     QDEPTH    = 4
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic            tk_brnch_i,
   input  logic [XLEN-1:0] target_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [XLEN-1:0] req_addr_o,
   input  logic            rsp_valid_i,
   input  logic [XLEN-1:0] rsp_data_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   localparam int unsigned   CW      = cnt_width(QDEPTH);
   localparam int unsigned   EW      = 2 * XLEN;
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QDEPTH);
   localparam logic [XLEN-1:0] STEP  = XLEN'(FETCH_BYTES);

   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [XLEN-1:0] rpc_q, rpc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   q_count;
   logic            q_full, q_empty;
   logic [EW-1:0]   q_rdata;
   logic [CW:0]     credit_used;
   logic            accept, push, pop;

   // Handshakes and next state. Credit covers in-flight plus queued words so the queue never
   // overflows; req_valid_o is forced low while reset is asserted.
   always_comb begin
      credit_used   = {1'b0, inflight_q} + {1'b0, q_count};
      req_valid_o   = arstn_i && !tk_brnch_i && (credit_used < DEPTH_C);
      req_addr_o    = fpc_q;
      instr_valid_o = !q_empty;
      accept        = req_valid_o && req_ready_i;
      pop           = instr_valid_o && instr_ready_i && !tk_brnch_i;
      push          = rsp_valid_i && (drop_q == '0) && !tk_brnch_i;

      inflight_d = inflight_q + CW'(accept) - CW'(rsp_valid_i);
      fpc_d      = accept ? fpc_q + STEP : fpc_q;
      rpc_d      = rpc_q;
      drop_d     = drop_q;
      if (tk_brnch_i) begin
         // Everything still outstanding after this cycle belongs to the old path.
         fpc_d  = target_i;
         rpc_d  = target_i;
         drop_d = inflight_d;
      end else if (rsp_valid_i) begin
         if (drop_q != '0) begin
            drop_d = drop_q - CW'(1);
         end else begin
            rpc_d = rpc_q + STEP;
         end
      end
   end

   // PC and counter registers.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         fpc_q      <= RESET_VEC;
         rpc_q      <= RESET_VEC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fpc_q      <= fpc_d;
         rpc_q      <= rpc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH)
   ) u_fetch_fifo (
      .clk_i   (clk_i),
      .rst_ni  (arstn_i),
      .clr_i   (tk_brnch_i),
      .push_i  (push),
      .wdata_i ({rsp_data_i, rpc_q}),
      .pop_i   (pop),
      .rdata_o (q_rdata),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   assign instr_o    = q_rdata[EW-1:XLEN];
   assign instr_pc_o = q_rdata[XLEN-1:0];

   // A response with nothing outstanding means the memory side is broken.
   rsp_without_req_a: assert property (@(posedge clk_i) disable iff (!arstn_i)
      rsp_valid_i |-> (inflight_q != '0));

   // Credit accounting guarantees a free slot for every live response.
   no_overflow_a: assert property (@(posedge clk_i) disable iff (!arstn_i)
      push |-> !q_full);

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: randomized memory/consumer with a scoreboard of expected fetches.
module tb_if_prefetch;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned QDEPTH    = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic        dead;
   } pend_t;

   logic        clk_i = 1'b0;
   logic        arstn_i = 1'b0;
   logic        tk_brnch_i = 1'b0;
   logic [31:0] target_i = '0;
   logic        req_valid_o;
   logic        req_ready_i = 1'b0;
   logic [31:0] req_addr_o;
   logic        rsp_valid_i = 1'b0;
   logic [31:0] rsp_data_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   if_prefetch #(
      .XLEN      (XLEN),
      .RESET_VEC (RESET_VEC),
      .QDEPTH    (QDEPTH)
   ) dut (
      .clk_i         (clk_i),
      .arstn_i       (arstn_i),
      .tk_brnch_i    (tk_brnch_i),
      .target_i      (target_i),
      .req_valid_o   (req_valid_o),
      .req_ready_i   (req_ready_i),
      .req_addr_o    (req_addr_o),
      .rsp_valid_i   (rsp_valid_i),
      .rsp_data_i    (rsp_data_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o)
   );

   // Clock.
   always #5 clk_i = ~clk_i;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   // Stimulus knobs, written only by the main sequence.
   int unsigned req_pct   = 100;
   int unsigned rsp_pct   = 100;
   int unsigned pop_pct   = 100;
   int unsigned flush_pct = 0;
   logic        flush_on  = 1'b0;
   logic [31:0] flush_tgt = '0;

   // Reference state: memory's outstanding requests and the live fetch stream.
   pend_t       pend_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] model_fpc = RESET_VEC;
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   int          acc_cyc[$];
   int          pop_cyc[$];
   int          m_dead, m_live, m_qcnt;
   logic        m_rv, m_iv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] acc_at(input int i);
      return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] pop_at(input int i);
      return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic int pop_cyc_at(input int i);
      return (i < pop_cyc.size()) ? pop_cyc[i] : -1;
   endfunction

   function automatic int acc_cyc_at(input int i);
      return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
   endfunction

   // Drive memory, consumer and flush just after each rising edge.
   always @(posedge clk_i) begin
      #1;
      if (!arstn_i) begin
         req_ready_i   = 1'b0;
         rsp_valid_i   = 1'b0;
         rsp_data_i    = '0;
         instr_ready_i = 1'b0;
         tk_brnch_i    = 1'b0;
      end else begin
         req_ready_i   = ($urandom_range(99) < req_pct);
         rsp_valid_i   = (pend_q.size() > 0) && ($urandom_range(99) < rsp_pct);
         rsp_data_i    = (pend_q.size() > 0) ? mem_word(pend_q[0].addr) : '0;
         instr_ready_i = ($urandom_range(99) < pop_pct);
         if (flush_on) begin
            tk_brnch_i = 1'b1;
            target_i   = flush_tgt;
         end else if ($urandom_range(99) < flush_pct) begin
            tk_brnch_i = 1'b1;
            target_i   = $urandom() & 32'hFFFF_FFFC;
         end else begin
            tk_brnch_i = 1'b0;
         end
      end
   end

   // Monitor + reference model, sampled on the falling edge.
   always @(negedge clk_i) begin
      cyc++;
      if (!arstn_i) begin
         pend_q.delete();
         exp_q.delete();
         model_fpc = RESET_VEC;
      end else begin
         m_dead = 0;
         foreach (pend_q[i]) if (pend_q[i].dead) m_dead++;
         m_live = pend_q.size() - m_dead;
         m_qcnt = exp_q.size() - m_live;
         m_rv   = !tk_brnch_i && ((exp_q.size() + m_dead) < QDEPTH);
         m_iv   = (m_qcnt != 0);
         check("req_valid", req_valid_o, m_rv);
         check("instr_valid", instr_valid_o, m_iv);
         if (instr_valid_o && instr_ready_i && !tk_brnch_i && m_iv) begin
            check("instr_pc", instr_pc_o, exp_q[0]);
            check("instr_data", instr_o, mem_word(exp_q[0]));
            pop_log.push_back(instr_pc_o);
            pop_cyc.push_back(cyc);
            void'(exp_q.pop_front());
         end
         if (req_valid_o && req_ready_i) begin
            check("req_addr", req_addr_o, model_fpc);
            acc_log.push_back(req_addr_o);
            acc_cyc.push_back(cyc);
            exp_q.push_back(model_fpc);
            pend_q.push_back('{addr: req_addr_o, dead: 1'b0});
            model_fpc = model_fpc + 32'd4;
         end
         if (rsp_valid_i && pend_q.size() > 0) void'(pend_q.pop_front());
         if (tk_brnch_i) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].dead = 1'b1;
            model_fpc = target_i;
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(negedge clk_i);
      #1;
   endtask

   // Assert reset mid-cycle, check outputs drop at once, then release mid-cycle.
   task automatic apply_reset();
      @(posedge clk_i);
      #3 arstn_i = 1'b0;
      #1;
      check("rst_req_valid", req_valid_o, 1'b0);
      check("rst_instr_valid", instr_valid_o, 1'b0);
      check("rst_req_addr", req_addr_o, RESET_VEC);
      repeat (2) @(posedge clk_i);
      #3 arstn_i = 1'b1;
   endtask

   int ab, pb;

   // Directed scenarios followed by randomized traffic.
   initial begin
      // Reset release, streaming one instruction per cycle.
      repeat (2) @(posedge clk_i);
      ab = acc_log.size();
      pb = pop_log.size();
      #3 arstn_i = 1'b1;
      cyc_wait(10);
      for (int i = 0; i < 3; i++) begin
         check("stream_req_addr", acc_at(ab + i), RESET_VEC + 32'(4 * i));
         check("stream_instr_pc", pop_at(pb + i), RESET_VEC + 32'(4 * i));
      end
      check("stream_latency", pop_cyc_at(pb), acc_cyc_at(ab) + 2);
      check("stream_back_to_back", pop_cyc_at(pb + 2), pop_cyc_at(pb) + 2);

      // Consumer stalled: credit stops requests at QDEPTH, one pop frees one slot.
      pop_pct = 0;
      apply_reset();
      ab = acc_log.size();
      cyc_wait(12);
      check("credit_stop_count", acc_log.size() - ab, 4);
      check("credit_stop_valid", req_valid_o, 1'b0);
      pop_pct = 100;
      cyc_wait(1);
      pop_pct = 0;
      cyc_wait(8);
      check("credit_one_more", acc_log.size() - ab, 5);

      // Three requests in flight, then redirect to 0x100.
      pop_pct = 100;
      rsp_pct = 0;
      apply_reset();
      ab = acc_log.size();
      for (int k = 0; k < 20 && (acc_log.size() - ab) < 3; k++) cyc_wait(1);
      req_pct = 0;
      check("inflight_three", acc_log.size() - ab, 3);
      cyc_wait(2);
      flush_tgt = 32'h100;
      flush_on  = 1'b1;
      cyc_wait(1);
      flush_on = 1'b0;
      req_pct  = 100;
      rsp_pct  = 100;
      ab = acc_log.size();
      pb = pop_log.size();
      cyc_wait(15);
      check("redirect_req_addr", acc_at(ab), 32'h100);
      check("redirect_first_pc", pop_at(pb), 32'h100);
      check("redirect_second_pc", pop_at(pb + 1), 32'h104);

      // Flush coinciding with a response and a pop.
      apply_reset();
      cyc_wait(8);
      flush_tgt = 32'h200;
      flush_on  = 1'b1;
      cyc_wait(1);
      check("flush_cycle_head_valid", instr_valid_o, 1'b1);
      flush_on = 1'b0;
      pb = pop_log.size();
      cyc_wait(1);
      check("flush_queue_empty", instr_valid_o, 1'b0);
      cyc_wait(10);
      check("flush_first_pc", pop_at(pb), 32'h200);

      // Fetch PC wraps past the top of the address space.
      apply_reset();
      cyc_wait(3);
      flush_tgt = 32'hFFFF_FFFC;
      flush_on  = 1'b1;
      cyc_wait(1);
      flush_on = 1'b0;
      ab = acc_log.size();
      pb = pop_log.size();
      cyc_wait(10);
      check("wrap_req_top", acc_at(ab), 32'hFFFF_FFFC);
      check("wrap_req_zero", acc_at(ab + 1), 32'h0);
      check("wrap_pc_top", pop_at(pb), 32'hFFFF_FFFC);
      check("wrap_pc_zero", pop_at(pb + 1), 32'h0);

      // Reset mid-stream, fetching resumes at RESET_VEC.
      req_pct = 70;
      rsp_pct = 60;
      pop_pct = 60;
      cyc_wait(30);
      req_pct = 100;
      rsp_pct = 100;
      pop_pct = 100;
      apply_reset();
      ab = acc_log.size();
      cyc_wait(5);
      check("resume_req_addr", acc_at(ab), RESET_VEC);

      // Randomized traffic with occasional redirects and resets.
      for (int r = 0; r < 20; r++) begin
         req_pct   = $urandom_range(100, 20);
         rsp_pct   = $urandom_range(100, 20);
         pop_pct   = $urandom_range(100, 10);
         flush_pct = $urandom_range(5, 0);
         cyc_wait(100);
         if (r % 5 == 4) apply_reset();
      end
      flush_pct = 0;
      cyc_wait(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
